// File: rtl/decoder_seq_nto2n_pkg.sv
// Shared constants and types for the sequenced N-to-2**N one-hot decoder.
// Direction encoding and the per-cycle sequencer action live here.
package decoder_seq_nto2n_pkg;

    localparam int N_DEF       = 3;
    localparam int M_DEF       = 2 ** N_DEF;
    localparam int DWELL_W_DEF = 4;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_STEP,
        ACT_AUTO
    } act_e;

endpackage

// File: rtl/decoder_seq_nto2n_onehot_dec.sv
// Combinational N-to-M one-hot decoder with enable.
// Output bit 0 is the leftmost bit of the vector.
module onehot_dec #(
    parameter int N = 3,
    parameter int M = 2 ** N
) (
    input  logic         en,
    input  logic [N-1:0] a,
    output logic [0:M-1] y
);

    always_comb begin
        y = '0;
        if (en) begin
            y[a] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_seq_nto2n.sv
// Registered one-hot select with load / step / auto-scan sequencing.
// Position, dwell counter and wrap pulse are held here; decode is a sub-block.
module decoder_seq_nto2n
    import decoder_seq_nto2n_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               load,
    input  logic [N-1:0]       code,
    input  logic               step,
    input  logic               dir,
    input  logic               auto,
    input  logic [DWELL_W-1:0] dwell,
    output logic [0:2**N-1]    y,
    output logic [N-1:0]       pos,
    output logic               valid,
    output logic               wrap
);

    localparam int M = 2 ** N;

    logic               en_q;
    logic               valid_q;
    logic               wrap_q;
    logic [N-1:0]       pos_q;
    logic [DWELL_W-1:0] cnt_q;

    act_e         act;
    logic [N-1:0] pos_nx;
    logic         wrap_nx;
    logic         dwell_done;

    // Priority: load beats step beats auto; step and auto need a loaded position.
    always_comb begin
        act = ACT_HOLD;
        if (en) begin
            priority case (1'b1)
                load:            act = ACT_LOAD;
                step && valid_q: act = ACT_STEP;
                auto && valid_q: act = ACT_AUTO;
                default:         act = ACT_HOLD;
            endcase
        end
    end

    always_comb begin
        pos_nx  = pos_q;
        wrap_nx = 1'b0;
        if (dir == DIR_UP) begin
            pos_nx  = pos_q + 1'b1;
            wrap_nx = &pos_q;
        end else begin
            pos_nx  = pos_q - 1'b1;
            wrap_nx = ~|pos_q;
        end
    end

    // >= so a dwell lowered below the running count advances at once.
    assign dwell_done = (cnt_q >= dwell);

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            pos_q   <= '0;
            cnt_q   <= '0;
        end else begin
            en_q   <= en;
            wrap_q <= 1'b0;
            case (act)
                ACT_LOAD: begin
                    pos_q   <= code;
                    valid_q <= 1'b1;
                    cnt_q   <= '0;
                end
                ACT_STEP: begin
                    pos_q  <= pos_nx;
                    wrap_q <= wrap_nx;
                    cnt_q  <= '0;
                end
                ACT_AUTO: begin
                    if (dwell_done) begin
                        pos_q  <= pos_nx;
                        wrap_q <= wrap_nx;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    onehot_dec #(
        .N (N),
        .M (M)
    ) u_dec (
        .en (en_q & valid_q),
        .a  (pos_q),
        .y  (y)
    );

    assign pos   = pos_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_decoder_seq_nto2n.sv
// Directed bench for the sequenced one-hot decoder, N=3 and N=1 instances.
// Each scenario task drives vectors and checks hand-computed results.
module tb_decoder_seq_nto2n;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       en = 1'b0, load = 1'b0, step = 1'b0, dir = 1'b1, auto = 1'b0;
    logic [2:0] code = '0;
    logic [3:0] dwell = '0;
    logic [0:7] y;
    logic [2:0] pos;
    logic       valid, wrap;

    logic       en1 = 1'b0, load1 = 1'b0, step1 = 1'b0, dir1 = 1'b1, auto1 = 1'b0;
    logic [0:0] code1 = '0;
    logic [3:0] dwell1 = '0;
    logic [0:1] y1;
    logic [0:0] pos1;
    logic       valid1, wrap1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    decoder_seq_nto2n #(.N(3), .DWELL_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .code(code),
        .step(step), .dir(dir), .auto(auto), .dwell(dwell),
        .y(y), .pos(pos), .valid(valid), .wrap(wrap)
    );

    decoder_seq_nto2n #(.N(1), .DWELL_W(4)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .load(load1), .code(code1),
        .step(step1), .dir(dir1), .auto(auto1), .dwell(dwell1),
        .y(y1), .pos(pos1), .valid(valid1), .wrap(wrap1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; load = 1'b1; code = 3'd5;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (y !== 8'b0 || pos !== 3'd0 || valid !== 1'b0 || wrap !== 1'b0)
                $display("FAIL reset[%0d]: y=%b pos=%0d valid=%b wrap=%b, need 0", i, y, pos, valid, wrap);
            else passed++;
        end
        rst = 1'b0; load = 1'b0; step = 1'b1;
        tick();
        step = 1'b0;
        total++;
        if (valid !== 1'b0 || pos !== 3'd0 || y !== 8'b0)
            $display("FAIL step_unloaded: valid=%b pos=%0d y=%b, need 0/0/0", valid, pos, y);
        else passed++;
    endtask

    task automatic test_load_en();
        load = 1'b1; code = 3'd5;
        tick();
        load = 1'b0;
        total++;
        if (y !== 8'b00000100 || pos !== 3'd5 || valid !== 1'b1 || wrap !== 1'b0)
            $display("FAIL load5: y=%b pos=%0d valid=%b wrap=%b, need 00000100/5/1/0", y, pos, valid, wrap);
        else passed++;
        en = 1'b0;
        tick();
        total++;
        if (y !== 8'b0 || pos !== 3'd5)
            $display("FAIL en_off: y=%b pos=%0d, need 00000000/5", y, pos);
        else passed++;
        en = 1'b1;
        tick();
        total++;
        if (y !== 8'b00000100)
            $display("FAIL en_on: y=%b, need 00000100", y);
        else passed++;
    endtask

    task automatic test_step();
        logic [2:0] exp_p [5] = '{3'd7, 3'd0, 3'd1, 3'd0, 3'd7};
        logic       exp_w [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        load = 1'b1; code = 3'd6;
        tick();
        load = 1'b0;
        total++;
        if (pos !== 3'd6 || y !== 8'b00000010)
            $display("FAIL load6: pos=%0d y=%b, need 6/00000010", pos, y);
        else passed++;
        step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dir = (i < 3) ? 1'b1 : 1'b0;
            tick();
            total++;
            if (pos !== exp_p[i] || wrap !== exp_w[i])
                $display("FAIL step[%0d]: pos=%0d wrap=%b, need %0d/%b", i, pos, wrap, exp_p[i], exp_w[i]);
            else passed++;
        end
        step = 1'b0;
        tick();
        total++;
        if (pos !== 3'd7 || wrap !== 1'b0)
            $display("FAIL step_idle: pos=%0d wrap=%b, need 7/0", pos, wrap);
        else passed++;
    endtask

    task automatic test_auto();
        logic [2:0] ep;
        logic       ew;
        load = 1'b1; code = 3'd0;
        tick();
        load = 1'b0; auto = 1'b1; dwell = 4'd2; dir = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            ep = 3'((k / 3) % 8);
            ew = (k == 24);
            total++;
            if (pos !== ep || wrap !== ew)
                $display("FAIL auto_d2[%0d]: pos=%0d wrap=%b, need %0d/%b", k, pos, wrap, ep, ew);
            else passed++;
        end
        dwell = 4'd0;
        for (int k = 1; k <= 2; k++) begin
            tick();
            total++;
            if (pos !== 3'(k))
                $display("FAIL auto_d0[%0d]: pos=%0d, need %0d", k, pos, k);
            else passed++;
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp_p [3] = '{3'd3, 3'd3, 3'd4};
        dwell = 4'd2; auto = 1'b1;
        load = 1'b1; step = 1'b1; code = 3'd3; dir = 1'b1;
        tick();
        load = 1'b0; step = 1'b0;
        total++;
        if (pos !== 3'd3 || wrap !== 1'b0)
            $display("FAIL load_prio: pos=%0d wrap=%b, need 3/0", pos, wrap);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (pos !== exp_p[i])
                $display("FAIL cnt_restart[%0d]: pos=%0d, need %0d", i, pos, exp_p[i]);
            else passed++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0; auto = 1'b0;
        total++;
        if (y !== 8'b0 || pos !== 3'd0 || valid !== 1'b0 || wrap !== 1'b0)
            $display("FAIL rst_mid: y=%b pos=%0d valid=%b wrap=%b, need 0", y, pos, valid, wrap);
        else passed++;
    endtask

    task automatic test_n1();
        en1 = 1'b1; load1 = 1'b1; code1 = 1'b1;
        tick();
        load1 = 1'b0;
        total++;
        if (pos1 !== 1'b1 || y1 !== 2'b01 || wrap1 !== 1'b0)
            $display("FAIL n1_load: pos=%0d y=%b wrap=%b, need 1/01/0", pos1, y1, wrap1);
        else passed++;
        step1 = 1'b1; dir1 = 1'b1;
        tick();
        total++;
        if (pos1 !== 1'b0 || y1 !== 2'b10 || wrap1 !== 1'b1)
            $display("FAIL n1_up: pos=%0d y=%b wrap=%b, need 0/10/1", pos1, y1, wrap1);
        else passed++;
        dir1 = 1'b0;
        tick();
        step1 = 1'b0;
        total++;
        if (pos1 !== 1'b1 || y1 !== 2'b01 || wrap1 !== 1'b1)
            $display("FAIL n1_dn: pos=%0d y=%b wrap=%b, need 1/01/1", pos1, y1, wrap1);
        else passed++;
    endtask

    initial begin
        #2;
        test_reset();
        test_load_en();
        test_step();
        test_auto();
        test_priority();
        test_n1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decoder_seq_nto2n.md
Name: decoder_seq_nto2n

Overview:
Parametrised registered binary-to-one-hot decoder, the next generation of the 3-to-8 / 2-to-4 decoder pair. Adds a registered output, a load/step/auto-scan sequencer with wrap detection, up/down direction, and a programmable dwell counter. Drives one-hot row/segment/channel selects, for example display multiplexing or a bank-enable sweep, where the select must either jump to a code or walk through all codes.

Parameters:
N, 3, code width; output width M = 2**N
DWELL_W, 4, width of dwell-count input; auto mode advances once every (dwell+1) cycles

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  output enable; 0 forces y to all-zero, state held
load  input  1  load code into position register
code  input  N  binary code to load
step  input  1  single manual advance of position
dir  input  1  1 = up (+1), 0 = down (-1)
auto  input  1  1 = free-running scan using dwell
dwell  input  DWELL_W  extra cycles to hold each position in auto mode
y  output  [0:M-1]  one-hot select; y[i]=1 when position==i (index 0 is leftmost bit, same ordering as existing decoders)
pos  output  N  current binary position
valid  output  1  position has been loaded at least once since reset
wrap  output  1  one-cycle pulse on M-1->0 (up) or 0->M-1 (down) advance

Behaviour:
- Reset (rst=1 at posedge): y=0, pos=0, valid=0, wrap=0, dwell counter=0. Reset overrides all other inputs. Reset mid-scan aborts the scan immediately.
- All outputs are registered. An input sampled at edge k is reflected at edge k, i.e. visible after one cycle of latency.
- y = en_q & valid ? onehot(pos) : 0, where en_q is the registered en. While en=0: y=0 from the next cycle; pos, valid, and the dwell counter hold; no advance; wrap=0.
- Priority with en=1: load > step > auto.
- load: pos<=code, valid<=1, dwell counter<=0, wrap<=0. A load on the same cycle as step or auto ignores the step.
- step (load=0): if valid=1, pos<=pos±1 modulo M according to dir, dwell counter<=0. If valid=0, the step is ignored.
- auto (load=0, step=0, valid=1): the dwell counter increments each cycle. When the counter == dwell, pos advances per dir and the counter resets to 0. With dwell=0, pos advances every cycle. A dwell change mid-count takes effect at the next compare; if counter > new dwell, the counter advances and resets at wrap of DWELL_W.
  - Alternatively the counter compares with >=, advancing immediately. Decided: use >= to avoid the long stall.
- wrap: asserted for exactly the cycle after an advance that crosses M-1->0 (dir=1) or 0->M-1 (dir=0). It is never asserted on load, even if the loaded code equals 0 or M-1.
- dir is sampled per advance; a dir change reverses the direction from the current pos without skipping.
- N=1 must work: M=2, and up and down advances both toggle pos.

Decomposition:
- Shared package/header: M = 2**N localparam; direction constants DIR_UP=1, DIR_DN=0.
- One sub-module, onehot_dec, a purely combinational N-to-M decoder with enable (generalising decoder2to4) that converts pos to y. Sequencer and dwell counter sit in the top level.

Test Plan:
- rst=1 for 2 cycles with load=1, code=5 -> y=0, pos=0, valid=0 throughout; after release, step alone does nothing (valid stays 0).
- N=3, en=1, load code=5 -> next cycle y=00000100 (y[5]=1), pos=5, valid=1, wrap=0; then en=0 -> y=0, pos stays 5; en=1 -> y[5]=1 again.
- load 6, then step dir=1 three times -> pos 7, 0 (wrap=1 for that one cycle), 1; then dir=0 step twice -> pos 0, 7 (wrap=1).
- auto=1, dwell=2, dir=1, from pos=0 -> pos changes every 3 cycles: 0,0,0,1,1,1,2...; wrap pulses once after the 7->0 advance; dwell=0 -> advances every cycle.
- Simultaneous load=1 (code=3), step=1, auto=1 -> pos=3, dwell counter restarted, no wrap; rst asserted mid auto-scan -> all outputs 0 next cycle.
- N=1 instance: load 1, step dir=1 -> pos=0, wrap=1, y=10; step dir=0 -> pos=1, wrap=1, y=01.
